matrix_stream_loader: RTL and testbench

//  Writer side of the packed 5x5 matrix bus used by the matrix operator modules (transpose etc.).

---
 rtl/matrix_stream_loader_pkg.sv | 25 ++
 rtl/matrix_index_counter.sv | 38 +++
 rtl/matrix_stream_loader.sv | 99 +++++++++
 tb/tb_matrix_stream_loader.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_loader_pkg.sv
// Shared definitions for the packed 5x5 matrix bus: element width, layout and loader states.
package matrix_stream_loader_pkg;

    localparam int ELEM_W = 9;
    localparam int DIM    = 5;
    localparam int MAT_W  = DIM * DIM * ELEM_W;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit offset of element (r,c) inside the packed word; operator modules use the same layout.
    function automatic int unsigned slot_offset(input int unsigned r, input int unsigned c);
        return (DIM * r + c) * ELEM_W;
    endfunction

    // Logical sizes 2..5 are the only ones the operators understand.
    function automatic logic size_legal(input logic [IDX_W-1:0] s);
        return (s >= 3'd2) && (s <= 3'd5);
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major element index for an N x N matrix: column wraps at N-1 and carries into the row.
module matrix_index_counter
    import matrix_stream_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [IDX_W-1:0] n,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    logic [IDX_W-1:0] n_m1;

    assign n_m1 = n - 3'd1;
    assign last = (row == n_m1) && (col == n_m1);

    // Step through the matrix one accepted element at a time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == n_m1) begin
                col <= '0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// Collects row-major elements from a valid/ready stream into the packed 225-bit matrix word.
module matrix_stream_loader
    import matrix_stream_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  size,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    output logic              in_ready,
    output logic [MAT_W-1:0]  matrix_out,
    output logic              matrix_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    state_t            state_q;
    state_t            state_nx;
    logic [IDX_W-1:0]  n_q;
    logic [MAT_W-1:0]  matrix_q;
    logic              in_ready_q;
    logic              valid_q;
    logic              err_q;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              last;
    logic              start_ok;
    logic              start_bad;
    logic              accept;

    assign start_ok  = (state_q == ST_IDLE) && start && size_legal(size);
    assign start_bad = (state_q == ST_IDLE) && start && !size_legal(size);
    assign accept    = in_valid && in_ready_q;

    matrix_index_counter u_index (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_ok),
        .advance (accept),
        .n       (n_q),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    // Next-state decode: IDLE -> LOAD on a legal start, LOAD -> DONE on the final element,
    // DONE -> IDLE once the consumer takes the matrix.
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: if (start_ok)         state_nx = ST_LOAD;
            ST_LOAD: if (accept && last)   state_nx = ST_DONE;
            ST_DONE: if (out_ready)        state_nx = ST_IDLE;
            default:                       state_nx = ST_IDLE;
        endcase
    end

    // State and handshake flags are registered from the next state so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            n_q        <= '0;
        end else begin
            state_q    <= state_nx;
            in_ready_q <= (state_nx == ST_LOAD);
            valid_q    <= (state_nx == ST_DONE);
            err_q      <= start_bad;
            if (start_ok) n_q <= size;
        end
    end

    // Matrix register: cleared on a legal start, one slot written per accept, raw data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            matrix_q <= '0;
        end else if (start_ok) begin
            matrix_q <= '0;
        end else if (accept) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    if ((row == IDX_W'(r)) && (col == IDX_W'(c)))
                        matrix_q[slot_offset(r, c) +: ELEM_W] <= in_data;
                end
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign matrix_valid = valid_q;
    assign matrix_out   = matrix_q;
    assign err          = err_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for the matrix stream loader.
module tb_matrix_stream_loader;
    import matrix_stream_loader_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        size = 3'd0;
    logic              in_valid = 1'b0;
    logic [ELEM_W-1:0] in_data = '0;
    logic              in_ready;
    logic [MAT_W-1:0]  matrix_out;
    logic              matrix_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              err;

    int checks = 0;
    int passed = 0;
    logic [MAT_W-1:0]  exp_q[$];
    logic [ELEM_W-1:0] vals[25];

    matrix_stream_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .size         (size),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .matrix_out   (matrix_out),
        .matrix_valid (matrix_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [ELEM_W-1:0] slot(input logic [MAT_W-1:0] m, input int r, input int c);
        return m[(5 * r + c) * 9 +: 9];
    endfunction

    function automatic logic [MAT_W-1:0] build_expected(input int n);
        logic [MAT_W-1:0] m = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                m[(5 * r + c) * 9 +: 9] = vals[r * n + c];
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] transpose(input logic [MAT_W-1:0] m);
        logic [MAT_W-1:0] t = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                t[(5 * r + c) * 9 +: 9] = m[(5 * c + r) * 9 +: 9];
        return t;
    endfunction

    function automatic logic [MAT_W-1:0] pop_expected();
        if (exp_q.size() == 0) return {MAT_W{1'bx}};
        return exp_q.pop_front();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] s);
        start = 1'b1;
        size  = s;
        tick();
        start = 1'b0;
    endtask

    // Drive up to 'limit' elements from vals[]; gap!=0 idles in_valid every other cycle.
    task automatic feed(input int n, input int limit, input int gap, output int accepts, output bit dropped);
        int  cyc = 0;
        bit  phase = 1'b0;
        logic rdy, v;
        accepts = 0;
        dropped = 1'b0;
        while (accepts < limit && cyc < 400) begin
            rdy = in_ready;
            if (!rdy) dropped = 1'b1;
            v = (gap != 0) ? !phase : 1'b1;
            phase = ~phase;
            in_valid = v;
            in_data  = vals[accepts];
            @(posedge clk);
            if (v && rdy) accepts++;
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (accepts < limit) $display("FAIL feed_timeout accepts=%0d required=%0d", accepts, limit);
        else passed++;
        if (accepts == n * n) exp_q.push_back(build_expected(n));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready, matrix_valid, busy, err} !== 4'b0000)
            $display("FAIL reset_flags got=%b required=0000", {in_ready, matrix_valid, busy, err});
        else passed++;
        checks++;
        if (matrix_out !== '0) $display("FAIL reset_matrix got=%h required=0", matrix_out);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_3x3();
        int acc, bad;
        bit drop;
        logic [MAT_W-1:0] exp;
        for (int i = 0; i < 9; i++) vals[i] = ELEM_W'(i + 1);
        out_ready = 1'b1;
        do_start(3'd3);
        checks++;
        if ({in_ready, busy} !== 2'b11) $display("FAIL 3x3_load_entry got=%b required=11", {in_ready, busy});
        else passed++;
        feed(3, 9, 0, acc, drop);
        checks++;
        if ({matrix_valid, in_ready} !== 2'b10)
            $display("FAIL 3x3_latency valid_ready=%b required=10", {matrix_valid, in_ready});
        else passed++;
        exp = pop_expected();
        checks++;
        if (matrix_out !== exp) $display("FAIL 3x3_matrix got=%h required=%h", matrix_out, exp);
        else passed++;
        checks++;
        if ({slot(matrix_out,0,0), slot(matrix_out,0,2), slot(matrix_out,1,0), slot(matrix_out,2,2)}
            !== {9'd1, 9'd3, 9'd4, 9'd9})
            $display("FAIL 3x3_slots got=%0d,%0d,%0d,%0d required=1,3,4,9", slot(matrix_out,0,0),
                     slot(matrix_out,0,2), slot(matrix_out,1,0), slot(matrix_out,2,2));
        else passed++;
        bad = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if ((r >= 3 || c >= 3) && slot(matrix_out, r, c) !== '0) bad++;
        checks++;
        if (bad != 0) $display("FAIL 3x3_unused_zero nonzero_slots=%0d required=0", bad);
        else passed++;
        tick();
        checks++;
        if ({matrix_valid, busy} !== 2'b00 || matrix_out !== exp)
            $display("FAIL 3x3_return_idle valid_busy=%b required=00 out_kept=%0b", {matrix_valid, busy}, matrix_out === exp);
        else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_5x5_gaps();
        int acc, extra;
        bit drop;
        logic [MAT_W-1:0] exp;
        for (int i = 0; i < 25; i++) vals[i] = ELEM_W'(511 - i);
        out_ready = 1'b0;
        do_start(3'd5);
        feed(5, 25, 1, acc, drop);
        checks++;
        if (acc != 25 || drop) $display("FAIL 5x5_accepts got=%0d dropped=%0b required=25 dropped=0", acc, drop);
        else passed++;
        checks++;
        if (matrix_valid !== 1'b1) $display("FAIL 5x5_valid got=%b required=1", matrix_valid);
        else passed++;
        extra = 0;
        in_valid = 1'b1;
        in_data  = 9'h0;
        for (int i = 0; i < 3; i++) begin
            if (in_ready) extra++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (extra != 0) $display("FAIL 5x5_extra_accepts got=%0d required=0", extra);
        else passed++;
        exp = pop_expected();
        checks++;
        if (matrix_out !== exp) $display("FAIL 5x5_matrix got=%h required=%h", matrix_out, exp);
        else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (matrix_valid !== 1'b0) $display("FAIL 5x5_release got=%b required=0", matrix_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        int acc;
        bit drop, stable;
        logic [MAT_W-1:0] hold, exp;
        vals[0] = 9'h100; vals[1] = 9'h0AA; vals[2] = 9'h055; vals[3] = 9'h1FE;
        out_ready = 1'b0;
        do_start(3'd2);
        feed(2, 4, 0, acc, drop);
        hold = matrix_out;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!matrix_valid || matrix_out !== hold || in_ready || !busy) stable = 1'b0;
            if (i == 3) begin
                start = 1'b1;
                size  = 3'd3;
            end
            tick();
            start = 1'b0;
        end
        checks++;
        if (!stable) $display("FAIL bp_hold stable=%0b required=1", stable);
        else passed++;
        exp = pop_expected();
        checks++;
        if (hold !== exp) $display("FAIL bp_matrix got=%h required=%h", hold, exp);
        else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({matrix_valid, busy, in_ready} !== 3'b000)
            $display("FAIL bp_release got=%b required=000", {matrix_valid, busy, in_ready});
        else passed++;
    endtask

    task automatic test_illegal_size();
        logic [MAT_W-1:0] hold;
        logic [2:0] bad_sizes[4];
        bad_sizes[0] = 3'd6; bad_sizes[1] = 3'd1; bad_sizes[2] = 3'd0; bad_sizes[3] = 3'd7;
        hold = matrix_out;
        for (int k = 0; k < 4; k++) begin
            do_start(bad_sizes[k]);
            checks++;
            if ({err, busy, in_ready} !== 3'b100)
                $display("FAIL illegal_err size=%0d got=%b required=100", bad_sizes[k], {err, busy, in_ready});
            else passed++;
            tick();
            checks++;
            if (err !== 1'b0 || matrix_out !== hold)
                $display("FAIL illegal_pulse size=%0d err=%b required=0 out_kept=%0b", bad_sizes[k], err, matrix_out === hold);
            else passed++;
        end
    endtask

    task automatic test_reset_midload();
        int acc;
        bit drop;
        logic [MAT_W-1:0] exp;
        for (int i = 0; i < 16; i++) vals[i] = ELEM_W'(3 * i + 1);
        do_start(3'd4);
        feed(4, 7, 0, acc, drop);
        rst_n = 1'b0;
        tick();
        checks++;
        if ({in_ready, matrix_valid, busy, err} !== 4'b0000 || matrix_out !== '0)
            $display("FAIL midload_reset flags=%b required=0000 out=%h", {in_ready, matrix_valid, busy, err}, matrix_out);
        else passed++;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) vals[i] = ELEM_W'(9'h40 + i);
        out_ready = 1'b1;
        do_start(3'd4);
        feed(4, 16, 0, acc, drop);
        exp = pop_expected();
        checks++;
        if (matrix_valid !== 1'b1 || matrix_out !== exp)
            $display("FAIL midload_reload valid=%b out=%h required=%h", matrix_valid, matrix_out, exp);
        else passed++;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_round_trip();
        int acc, bad;
        bit drop;
        logic [MAT_W-1:0] exp, t;
        for (int i = 0; i < 25; i++) vals[i] = ELEM_W'((i * 37 + 5) % 512);
        out_ready = 1'b1;
        do_start(3'd5);
        feed(5, 25, 0, acc, drop);
        exp = pop_expected();
        checks++;
        if (matrix_out !== exp) $display("FAIL rt_matrix got=%h required=%h", matrix_out, exp);
        else passed++;
        t = transpose(matrix_out);
        bad = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (slot(t, r, c) !== vals[c * 5 + r]) bad++;
        checks++;
        if (bad != 0) $display("FAIL rt_transpose wrong_slots=%0d required=0", bad);
        else passed++;
        tick();
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_3x3();
        test_5x5_gaps();
        test_backpressure();
        test_illegal_size();
        test_reset_midload();
        test_round_trip();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t required=completion", $time);
        $fatal(1);
    end

endmodule
